// File: rtl/lsu_data_memory.sv
// Single-port LSU data memory: power-on clear sweep, then single-cycle byte/half/word
// loads and stores with a registered one-cycle response.

module lsu_byte_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic [7:0] b_lo,
  input  logic [7:0] b_hi,
  input  logic [7:0] b_word,
  output logic       be,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LN = 2'(LANE);

  always_comb begin
    be    = 1'b0;
    wbyte = b_lo;
    case (size)
      2'b00: be = (addr_lo == LN);
      2'b01: begin
        be    = (addr_lo[1] == LN[1]);
        wbyte = LN[0] ? b_hi : b_lo;
      end
      2'b10: begin
        be    = 1'b1;
        wbyte = b_word;
      end
      default: ;
    endcase
  end
endmodule

module lsu_data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IW        = ADDR_WIDTH - 2;
  localparam int DEPTH     = 1 << IW;
  localparam logic [IW-1:0] LAST = '1;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_data_memory supports only DATA_WIDTH = 32");
  end

  typedef enum logic {INIT, READY} state_t;

  typedef struct packed {
    logic                  write;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t        state, state_nx;
  logic [IW-1:0] clr_idx, clr_idx_nx;
  logic          clr_en;
  req_t          req;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wb;

  logic                  accept, misalign, st_en;
  logic [IW-1:0]         widx;
  logic [DATA_WIDTH-1:0] rd_word, ld_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign req = '{write: req_write, size: req_size, uns: req_unsigned,
                 addr: req_addr, wdata: req_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // Ready is masked by rst so a request in the reset cycle is never accepted.
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    clr_en     = 1'b0;
    req_ready  = 1'b0;
    case (state)
      INIT: begin
        clr_en     = 1'b1;
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == LAST) state_nx = READY;
      end
      READY:   req_ready = !rst;
      default: state_nx = INIT;
    endcase
  end

  assign accept   = req_valid & req_ready;
  assign misalign = (req.size == 2'b11) ||
                    (req.size == 2'b01 && req.addr[0]) ||
                    (req.size == 2'b10 && req.addr[1:0] != 2'b00);
  assign st_en    = accept & req.write & !misalign;
  assign widx     = req.addr[ADDR_WIDTH-1:2];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_byte_lane #(.LANE(i)) u_lane (
      .size    (req.size),
      .addr_lo (req.addr[1:0]),
      .b_lo    (req.wdata[7:0]),
      .b_hi    (req.wdata[15:8]),
      .b_word  (req.wdata[8*i +: 8]),
      .be      (lane_be[i]),
      .wbyte   (lane_wb[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) mem[clr_idx] <= '0;
      else if (st_en) begin
        for (int l = 0; l < NUM_LANES; l++)
          if (lane_be[l]) mem[widx][l] <= lane_wb[l];
      end
    end
  end

  // Read is combinational off the array, so a store landing on the previous
  // edge is already visible to the next load.
  assign rd_word  = mem[widx];
  assign byte_sel = rd_word[{req.addr[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{req.addr[1], 4'b0000} +: 16];

  always_comb begin
    case (req.size)
      2'b00:   ld_data = req.uns ? {{(DATA_WIDTH-8){1'b0}}, byte_sel}
                                 : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = req.uns ? {{(DATA_WIDTH-16){1'b0}}, half_sel}
                                 : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_error <= misalign;
      rsp_rdata <= (misalign || req.write) ? '0 : ld_data;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end
  end
endmodule

// File: doc/lsu_data_memory.md
LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, byte-address width; memory holds 2**(ADDR_WIDTH-2) 32-bit words (DEPTH).
REQ-002 Parameter DATA_WIDTH, default 32, data width; only 32 is supported, elaboration SHALL fail otherwise.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock, sole clock of the block.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  ADDR_WIDTH  byte address, little-endian.
REQ-012 req_wdata  in  DATA_WIDTH  store data; low 8/16/32 bits used per size.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_rdata  out  DATA_WIDTH  load result, extended per size/unsigned.
REQ-015 rsp_error  out  1  request was misaligned or reserved size.

Function
REQ-016 The state machine SHALL have states INIT and READY; rst forces INIT with clear index 0.
REQ-017 In INIT the block SHALL write zero to word[clear index] each cycle, increment the index, and move to READY after word DEPTH-1 is cleared (DEPTH cycles total).
REQ-018 req_ready SHALL be 1 only in READY; req_valid in INIT is ignored with no side effects.
REQ-019 A request is accepted on a rising edge with req_valid=1 and req_ready=1; every request is single-cycle and back-to-back acceptance SHALL be supported.
REQ-020 rsp_valid SHALL assert exactly one cycle after acceptance, for one cycle, with rsp_rdata/rsp_error registered.
REQ-021 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11; SHALL set rsp_error=1, rsp_rdata=0, no memory change.
REQ-022 Store SHALL update only the addressed bytes of word[addr>>2] (byte lane addr[1:0], halfword lane addr[1]); other bytes preserved.
REQ-023 Load SHALL select the addressed byte/halfword/word and extend to 32 bits per req_unsigned; req_unsigned is ignored for word loads.
REQ-024 Store response SHALL have rsp_rdata=0 and rsp_error=0 when aligned.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the stored data (no read hazard).
REQ-026 Outside a response cycle rsp_valid, rsp_error SHALL be 0 and rsp_rdata SHALL be 0.

Reset
REQ-027 rst SHALL have priority over any request in the same cycle; the request is dropped, no response is generated.
REQ-028 During and on the cycle after rst: req_ready=0, rsp_valid=0, rsp_error=0, rsp_rdata=0.
REQ-029 Asserting rst mid-INIT SHALL restart clearing from index 0; asserting it in READY SHALL re-clear the whole memory.

Verification
REQ-030 Reset 2 cycles, release: req_ready=0 for exactly 64 cycles (ADDR_WIDTH=8), then 1; word loads at 0x00, 0x04, 0x08 return 0x00000000, rsp_error=0.
REQ-031 Word store 0xcafebabe @0x04, then loads: word @0x04 -> 0xcafebabe; signed byte @0x05 -> 0xffffffba; unsigned byte @0x05 -> 0x000000ba; signed half @0x06 -> 0xffffcafe.
REQ-032 Byte store 0x11 @0x07 after REQ-031 -> word load @0x04 returns 0x11febabe; half store 0x1234 @0x04 -> 0x11fe1234.
REQ-033 Word store 0x11111111 @0x02 and half store @0x05 -> rsp_error=1, rsp_rdata=0; word load @0x00 unchanged; size 11 load -> rsp_error=1.
REQ-034 Back-to-back: store 0xdeadbeef @0x08 then load @0x08 on the next cycle -> rsp_valid on two consecutive cycles, second rsp_rdata=0xdeadbeef.
REQ-035 Store 0x12345678 @0x0c, assert rst concurrently with a store 0xffffffff @0x0c -> no response; after re-init load @0x0c returns 0x00000000; random aligned store/load pairs of all sizes match a reference model.
